alu_seq: RTL and testbench

- Parametrised multi-cycle ALU for the CPU execute stage, replacing single-cycle combinational ALU use where M-extension ops are needed.
- Performs all base ALU ops plus MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, using iterative shift-add and restoring-division datapaths.
- Valid/ready handshake on both input and output, so the control unit stalls on BUSY.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake bundle between the execute-stage control unit and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [4:0]       ctl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_err;
  logic             busy;

  modport master (
    output flush, in_valid, op1, op2, ctl, out_ready,
    input  in_ready, out_valid, out, out_err, busy
  );

  modport slave (
    input  flush, in_valid, op1, op2, ctl, out_ready,
    output in_ready, out_valid, out, out_err, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU. Base ops finish in one cycle; M-extension ops run
// WIDTH shift-add / restoring-divide iterations on magnitudes, then a FIX cycle
// applies sign correction and picks the high/low half.
// CTL encoding: 0..13 base ops, 16..23 = MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU.
module alu_seq #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_AND = 5'd2,
                         ALU_OR  = 5'd3,  ALU_XOR = 5'd4,  ALU_SLL = 5'd5,
                         ALU_SRL = 5'd6,  ALU_SRA = 5'd7,  ALU_EQ  = 5'd8,
                         ALU_NE  = 5'd9,  ALU_LT  = 5'd10, ALU_GE  = 5'd11,
                         ALU_LTU = 5'd12, ALU_GEU = 5'd13;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic             accept, is_md, cnt_done;
  logic [WIDTH-1:0] sc_res, md_res, out_q;
  logic             sc_err, err_q;
  logic [SHW-1:0]   shamt;

  assign is_md         = MULDIV_EN && (bus.ctl[4:3] == 2'b10);
  assign bus.in_ready  = ((state == IDLE) || ((state == DONE) && bus.out_ready)) && !bus.flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out       = out_q;
  assign bus.out_err   = err_q;
  assign shamt         = bus.op2[SHW-1:0];

  // single-cycle result; anything not decoded here is illegal
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (bus.ctl)
      ALU_ADD: sc_res = bus.op1 + bus.op2;
      ALU_SUB: sc_res = bus.op1 - bus.op2;
      ALU_AND: sc_res = bus.op1 & bus.op2;
      ALU_OR:  sc_res = bus.op1 | bus.op2;
      ALU_XOR: sc_res = bus.op1 ^ bus.op2;
      ALU_SLL: sc_res = bus.op1 << shamt;
      ALU_SRL: sc_res = bus.op1 >> shamt;
      ALU_SRA: sc_res = $signed(bus.op1) >>> shamt;
      ALU_EQ:  sc_res = WIDTH'(bus.op1 == bus.op2);
      ALU_NE:  sc_res = WIDTH'(bus.op1 != bus.op2);
      ALU_LT:  sc_res = WIDTH'($signed(bus.op1) < $signed(bus.op2));
      ALU_GE:  sc_res = WIDTH'($signed(bus.op1) >= $signed(bus.op2));
      ALU_LTU: sc_res = WIDTH'(bus.op1 < bus.op2);
      ALU_GEU: sc_res = WIDTH'(bus.op1 >= bus.op2);
      default: sc_err = 1'b1;
    endcase
  end

  // next state; flush overrides everything and blocks accept via in_ready
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_md ? ITER : DONE;
      ITER: if (cnt_done) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: begin
        if (accept)             state_nx = is_md ? ITER : DONE;
        else if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // result register: loaded on single-cycle accept or at the end of FIX;
  // untouched otherwise so it stays stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else if (bus.flush) begin
      err_q <= 1'b0;
    end else if (accept) begin
      if (!is_md) out_q <= sc_res;
      err_q <= is_md ? 1'b0 : sc_err;
    end else if (state == FIX) begin
      out_q <= md_res;
      err_q <= 1'b0;
    end
  end

  generate
    if (MULDIV_EN) begin : g_md
      logic [CW-1:0]      cnt;
      logic [WIDTH-1:0]   hi, lo, dvs;
      logic [2:0]         fn;
      logic               neg, sgn1_q, dz;
      logic               s1_op, s2_op, sgn1, sgn2;
      logic [WIDTH-1:0]   mag1, mag2;
      logic [WIDTH:0]     msum, rsh, rdiff;
      logic [2*WIDTH-1:0] prod;

      // which operands are signed for this op (fn = ctl[2:0])
      always_comb begin
        s1_op = 1'b0;
        s2_op = 1'b0;
        case (bus.ctl[2:0])
          3'd1, 3'd4, 3'd6: begin s1_op = 1'b1; s2_op = 1'b1; end
          3'd2:             s1_op = 1'b1;
          default: ;
        endcase
        sgn1 = s1_op & bus.op1[WIDTH-1];
        sgn2 = s2_op & bus.op2[WIDTH-1];
        mag1 = sgn1 ? -bus.op1 : bus.op1;
        mag2 = sgn2 ? -bus.op2 : bus.op2;
      end

      // one iteration step: shift-add for mul, compare/subtract for div
      always_comb begin
        msum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        rsh   = {hi, lo[WIDTH-1]};
        rdiff = rsh - {1'b0, dvs};
      end

      // sign fix-up and half select; dz quotient is forced to all-ones,
      // dz remainder falls out as OP1 since the dividend ends up in hi
      always_comb begin
        md_res = '0;
        prod   = {hi, lo};
        if (neg) prod = -prod;
        case (fn)
          3'd0:             md_res = prod[WIDTH-1:0];
          3'd1, 3'd2, 3'd3: md_res = prod[2*WIDTH-1:WIDTH];
          3'd4, 3'd5:       md_res = dz ? '1 : (neg ? -lo : lo);
          default:          md_res = sgn1_q ? -hi : hi;
        endcase
      end

      assign cnt_done = (cnt == CW'(WIDTH - 1));

      // operand latch at accept, then one iteration per ITER cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          hi     <= '0;
          lo     <= '0;
          dvs    <= '0;
          fn     <= '0;
          neg    <= 1'b0;
          sgn1_q <= 1'b0;
          dz     <= 1'b0;
        end else if (bus.flush) begin
          cnt <= '0;
        end else if (accept && is_md) begin
          cnt    <= '0;
          fn     <= bus.ctl[2:0];
          hi     <= '0;
          neg    <= sgn1 ^ sgn2;
          sgn1_q <= sgn1;
          dz     <= (bus.op2 == '0);
          if (bus.ctl[2]) begin
            lo  <= mag1;
            dvs <= mag2;
          end else begin
            lo  <= mag2;
            dvs <= mag1;
          end
        end else if (state == ITER) begin
          cnt <= cnt + 1'b1;
          if (fn[2]) begin
            if (!rdiff[WIDTH]) begin
              hi <= rdiff[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= rsh[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= msum[WIDTH:1];
            lo <= {msum[0], lo[WIDTH-1:1]};
          end
        end
      end
    end else begin : g_nomd
      assign cnt_done = 1'b0;
      assign md_res   = '0;
    end
  endgenerate
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): directed cases, backpressure,
// flush, async reset and a short random mix checked against a behavioural model.
module tb_alu_seq;
  localparam logic [4:0] C_ADD = 5'd0,  C_SUB = 5'd1,  C_AND = 5'd2,  C_OR  = 5'd3,
                         C_XOR = 5'd4,  C_SLL = 5'd5,  C_SRL = 5'd6,  C_SRA = 5'd7,
                         C_EQ  = 5'd8,  C_NE  = 5'd9,  C_LT  = 5'd10, C_GE  = 5'd11,
                         C_LTU = 5'd12, C_GEU = 5'd13,
                         C_MUL = 5'd16, C_MULH = 5'd17, C_MULHSU = 5'd18, C_MULHU = 5'd19,
                         C_DIV = 5'd20, C_DIVU = 5'd21, C_REM = 5'd22, C_REMU = 5'd23;
  localparam logic [4:0] CODES [22] = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_SLL, C_SRL,
    C_SRA, C_EQ, C_NE, C_LT, C_GE, C_LTU, C_GEU, C_MUL, C_MULH, C_MULHSU, C_MULHU,
    C_DIV, C_DIVU, C_REM, C_REMU};

  typedef struct {
    logic [31:0] out;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_err = 0, cyc = 0;
  exp_t  sb[$];
  string tags[$];

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [4:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sbx, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a}; sbx = {{32{b[31]}}, b}; ua = {32'd0, a}; ub = {32'd0, b};
    r = '0;
    case (c)
      C_ADD: r = a + b;
      C_SUB: r = a - b;
      C_AND: r = a & b;
      C_OR:  r = a | b;
      C_XOR: r = a ^ b;
      C_SLL: r = a << b[4:0];
      C_SRL: r = a >> b[4:0];
      C_SRA: r = 32'($signed(a) >>> b[4:0]);
      C_EQ:  r = {31'd0, a == b};
      C_NE:  r = {31'd0, a != b};
      C_LT:  r = {31'd0, $signed(a) < $signed(b)};
      C_GE:  r = {31'd0, $signed(a) >= $signed(b)};
      C_LTU: r = {31'd0, a < b};
      C_GEU: r = {31'd0, a >= b};
      C_MUL:    begin p = ua * ub;  r = p[31:0];  end
      C_MULH:   begin p = sa * sbx; r = p[63:32]; end
      C_MULHSU: begin p = sa * ub;  r = p[63:32]; end
      C_MULHU:  begin p = ua * ub;  r = p[63:32]; end
      C_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'($signed(a) / $signed(b));
      end
      C_DIVU: begin
        if (b == 0) r = '1;
        else r = a / b;
      end
      C_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = 32'($signed(a) % $signed(b));
      end
      C_REMU: begin
        if (b == 0) r = a;
        else r = a % b;
      end
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] pick_opd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // call just after a posedge; returns #1 after the accepting edge
  task automatic issue(input string tag, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo, input logic ee);
    int   n = 0;
    exp_t e;
    bus.ctl = c; bus.op1 = a; bus.op2 = b; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin n++; @(negedge clk); end
    if (!bus.in_ready) chk({tag, "_accept_timeout"}, 64'(bus.in_ready), 64'd1);
    else begin
      e.out = eo; e.err = ee; e.lat = (c[4:3] == 2'b10) ? 34 : 1; e.acc = cyc + 1;
      sb.push_back(e);
      tags.push_back(tag);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin n++; @(negedge clk); end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete(); tags.delete();
    end
    @(posedge clk); #1;
  endtask

  // edge counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // output monitor: compares every consumed result against the scoreboard
  initial begin
    bit    fresh = 1'b1;
    int    rise = 0;
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.out_valid) fresh = 1'b1;
      else begin
        if (fresh) begin rise = cyc; fresh = 1'b0; end
        if (bus.out_ready) begin
          if (sb.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
          else begin
            e = sb.pop_front(); t = tags.pop_front();
            chk({t, "_out"}, 64'(bus.out), 64'(e.out));
            chk({t, "_err"}, 64'(bus.out_err), 64'(e.err));
            chk({t, "_lat"}, 64'(rise - e.acc + 1), 64'(e.lat));
          end
          fresh = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int          bad;
    logic [32:0] m;
    logic [4:0]  c;
    logic [31:0] a, b;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op1 = '0; bus.op2 = '0;
    bus.ctl = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // single-cycle ops
    issue("add", C_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    @(posedge clk); #1;
    chk("add_valid_one_cycle", 64'(bus.out_valid), 64'd0);
    issue("sll", C_SLL, 32'd1, 32'd33, 32'd2, 1'b0);
    issue("geu", C_GEU, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    issue("sra", C_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    issue("lt", C_LT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    issue("illegal", 5'd31, 32'd1, 32'd2, 32'd0, 1'b1);
    drain();

    // multiply
    issue("mul", C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (!bus.busy || bus.in_ready || bus.out_valid) bad++;
    end
    chk("mul_busy_window", 64'(bad), 64'd0);
    @(posedge clk); #1;
    issue("mulhu", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue("mulh", C_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    issue("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // divide
    issue("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    issue("div_m7", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    issue("rem_m7", C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    issue("divu_z", C_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);
    issue("remu_z", C_REMU, 32'd9, 32'd0, 32'd9, 1'b0);
    drain();

    // backpressure then simultaneous consume + accept
    bus.out_ready = 1'b0;
    issue("mul_bp", C_MUL, 32'd3, 32'd4, 32'd12, 1'b0);
    bad = 0;
    while (!bus.out_valid && bad < 100) begin bad++; @(negedge clk); end
    chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out !== 32'd12 || !bus.out_valid || bus.out_err || bus.in_ready) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue("add_bp", C_ADD, 32'd1, 32'd1, 32'd2, 1'b0);
    drain();

    // flush mid-divide
    issue("div_flushed", C_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    void'(sb.pop_back()); void'(tags.pop_back());
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("post_flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_flush_busy", 64'(bus.busy), 64'd0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) bad++; end
    chk("flush_no_valid", 64'(bad), 64'd0);
    @(posedge clk); #1;
    issue("add_after_flush", C_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
    drain();

    // async reset mid-multiply
    issue("mul_reset", C_MUL, 32'd6, 32'd7, 32'd42, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    void'(sb.pop_back()); void'(tags.pop_back());
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out", 64'(bus.out), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    bad = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid || bus.busy) bad++; end
    chk("arst_no_pending", 64'(bad), 64'd0);
    @(posedge clk); #1;

    // random mix against the model
    for (int i = 0; i < 24; i++) begin
      c = CODES[$urandom_range(0, 21)];
      a = pick_opd();
      b = pick_opd();
      m = model(c, a, b);
      issue($sformatf("rnd%0d_c%0d", i, c), c, a, b, m[31:0], m[32]);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
